// File: rtl/dot_window_tracker.sv
// Sliding-window slot tracker: fills a WIN-deep window, then rings the oldest-slot
// pointer, emitting strided window-valid pulses plus column/row position tracking.
module dot_window_tracker #(
    parameter int WIN   = 5,
    parameter int CW    = $clog2(WIN + 1),
    parameter int PW    = ($clog2(WIN) < 1) ? 1 : $clog2(WIN),
    parameter int SW    = 4,
    parameter int COL_W = 8,
    parameter int ROW_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             rowend,
    input  logic             frame_start,
    input  logic [SW-1:0]    stride,
    output logic [CW-1:0]    cnt,
    output logic [PW-1:0]    first_dot,
    output logic [PW-1:0]    wr_slot,
    output logic             win_valid,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             col_ovf
);

    localparam int SW1 = SW + 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(WIN);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIN - 1);
    localparam logic [PW-1:0] SLOT_LAST = PW'(WIN - 1);

    logic [SW-1:0]  sph;
    logic           full;
    logic [SW-1:0]  eff_stride;
    logic [SW:0]    sph_inc;
    logic [SW-1:0]  sph_nxt;
    logic [COL_W:0] col_inc;

    assign full       = (cnt == CNT_FULL);
    assign eff_stride = (stride == '0) ? SW'(1) : stride;
    assign sph_inc    = {1'b0, sph} + SW1'(1);
    // Compare against the live stride so a shrink below the current phase forces a pulse.
    assign sph_nxt    = (sph_inc >= {1'b0, eff_stride}) ? '0 : sph_inc[SW-1:0];
    assign col_inc    = {1'b0, col} + (COL_W + 1)'(1);
    assign wr_slot    = full ? first_dot : cnt[PW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            first_dot <= '0;
            sph       <= '0;
            win_valid <= 1'b0;
            col       <= '0;
            row       <= '0;
            col_ovf   <= 1'b0;
        end else if (frame_start) begin
            cnt       <= '0;
            first_dot <= '0;
            sph       <= '0;
            win_valid <= 1'b0;
            col       <= '0;
            row       <= '0;
            col_ovf   <= 1'b0;
        end else if (rowend) begin
            cnt       <= '0;
            first_dot <= '0;
            sph       <= '0;
            win_valid <= 1'b0;
            col       <= '0;
            row       <= row + ROW_W'(1);
        end else if (enable) begin
            col <= col_inc[COL_W-1:0];
            if (col_inc[COL_W]) begin
                col_ovf <= 1'b1;
            end
            if (!full) begin
                cnt       <= cnt + CW'(1);
                win_valid <= (cnt == CNT_LAST);
                if (cnt == CNT_LAST) begin
                    sph <= '0;
                end
            end else begin
                first_dot <= (first_dot == SLOT_LAST) ? '0 : first_dot + PW'(1);
                sph       <= sph_nxt;
                win_valid <= (sph_nxt == '0);
            end
        end else begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dot_window_tracker.sv
// Scoreboard bench for dot_window_tracker: three instances (WIN=5/COL_W=8, WIN=5/COL_W=3,
// WIN=3) share one directed input stream; expected values are hand-computed per step.
module tb_dot_window_tracker;

    typedef struct {
        int idx;
        int ws, cnt, fd, wv, col, row;
        int bcol, bovf;
        int ccnt, cfd, cwv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, rowend, frame_start;
    logic [3:0] stride;

    logic [2:0] a_cnt, a_fd, a_ws;
    logic       a_wv, a_ovf;
    logic [7:0] a_col, a_row;

    logic [2:0] b_cnt, b_fd, b_ws;
    logic       b_wv, b_ovf;
    logic [2:0] b_col;
    logic [7:0] b_row;

    logic [1:0] c_cnt, c_fd, c_ws;
    logic       c_wv, c_ovf;
    logic [7:0] c_col, c_row;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   step_no  = 0;

    always #5 clk = ~clk;

    dot_window_tracker #(.WIN(5), .SW(4), .COL_W(8), .ROW_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rowend(rowend),
        .frame_start(frame_start), .stride(stride), .cnt(a_cnt), .first_dot(a_fd),
        .wr_slot(a_ws), .win_valid(a_wv), .col(a_col), .row(a_row), .col_ovf(a_ovf)
    );

    dot_window_tracker #(.WIN(5), .SW(4), .COL_W(3), .ROW_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rowend(rowend),
        .frame_start(frame_start), .stride(stride), .cnt(b_cnt), .first_dot(b_fd),
        .wr_slot(b_ws), .win_valid(b_wv), .col(b_col), .row(b_row), .col_ovf(b_ovf)
    );

    dot_window_tracker #(.WIN(3), .SW(4), .COL_W(8), .ROW_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rowend(rowend),
        .frame_start(frame_start), .stride(stride), .cnt(c_cnt), .first_dot(c_fd),
        .wr_slot(c_ws), .win_valid(c_wv), .col(c_col), .row(c_row), .col_ovf(c_ovf)
    );

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Drive one cycle of inputs and queue what each instance must show after the edge.
    task automatic step(input logic en, input logic re, input logic fs, input logic [3:0] st,
                        input int ws, input int cnt, input int fd, input int wv,
                        input int col, input int row, input int bcol, input int bovf,
                        input int ccnt, input int cfd, input int cwv);
        exp_t e;
        @(negedge clk);
        enable      = en;
        rowend      = re;
        frame_start = fs;
        stride      = st;
        step_no++;
        e.idx = step_no; e.ws = ws; e.cnt = cnt; e.fd = fd; e.wv = wv; e.col = col; e.row = row;
        e.bcol = bcol; e.bovf = bovf; e.ccnt = ccnt; e.cfd = cfd; e.cwv = cwv;
        q.push_back(e);
        @(posedge clk);
        #2;
        enable      = 1'b0;
        rowend      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    task automatic zero_checks(input string tag);
        chk({tag, "_a_cnt"}, int'(a_cnt), 0);
        chk({tag, "_a_fd"},  int'(a_fd), 0);
        chk({tag, "_a_ws"},  int'(a_ws), 0);
        chk({tag, "_a_wv"},  int'(a_wv), 0);
        chk({tag, "_a_col"}, int'(a_col), 0);
        chk({tag, "_a_row"}, int'(a_row), 0);
        chk({tag, "_a_ovf"}, int'(a_ovf), 0);
        chk({tag, "_b_col"}, int'(b_col), 0);
        chk({tag, "_b_ovf"}, int'(b_ovf), 0);
        chk({tag, "_c_cnt"}, int'(c_cnt), 0);
        chk({tag, "_c_fd"},  int'(c_fd), 0);
        chk({tag, "_c_wv"},  int'(c_wv), 0);
    endtask

    // Monitor: wr_slot is sampled before the edge, registered outputs after it.
    initial begin
        int   ws_pre;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            ws_pre = int'(a_ws);
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk($sformatf("ws[%0d]", e.idx),    ws_pre, e.ws);
                chk($sformatf("cnt[%0d]", e.idx),   int'(a_cnt), e.cnt);
                chk($sformatf("fd[%0d]", e.idx),    int'(a_fd), e.fd);
                chk($sformatf("wv[%0d]", e.idx),    int'(a_wv), e.wv);
                chk($sformatf("col[%0d]", e.idx),   int'(a_col), e.col);
                chk($sformatf("row[%0d]", e.idx),   int'(a_row), e.row);
                chk($sformatf("b_col[%0d]", e.idx), int'(b_col), e.bcol);
                chk($sformatf("b_ovf[%0d]", e.idx), int'(b_ovf), e.bovf);
                chk($sformatf("c_cnt[%0d]", e.idx), int'(c_cnt), e.ccnt);
                chk($sformatf("c_fd[%0d]", e.idx),  int'(c_fd), e.cfd);
                chk($sformatf("c_wv[%0d]", e.idx),  int'(c_wv), e.cwv);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; rowend = 1'b0; frame_start = 1'b0; stride = 4'd1;
        repeat (2) @(posedge clk);
        #3;
        zero_checks("reset");
        rst_n = 1'b1;

        //    en re fs st  ws cnt fd wv col row  bcol bovf  ccnt cfd cwv
        // fill with stride 1
        step(1,0,0,1,  0,1,0,0,1,0,   1,0,  1,0,0);
        step(1,0,0,1,  1,2,0,0,2,0,   2,0,  2,0,0);
        step(1,0,0,1,  2,3,0,0,3,0,   3,0,  3,0,1);
        step(1,0,0,1,  3,4,0,0,4,0,   4,0,  3,1,1);
        step(1,0,0,1,  4,5,0,1,5,0,   5,0,  3,2,1);
        // full phase, ring wraps; COL_W=3 instance wraps on 8th enable
        step(1,0,0,1,  0,5,1,1,6,0,   6,0,  3,0,1);
        step(1,0,0,1,  1,5,2,1,7,0,   7,0,  3,1,1);
        step(1,0,0,1,  2,5,3,1,8,0,   0,1,  3,2,1);
        step(1,0,0,1,  3,5,4,1,9,0,   1,1,  3,0,1);
        step(1,0,0,1,  4,5,0,1,10,0,  2,1,  3,1,1);
        step(1,0,0,1,  0,5,1,1,11,0,  3,1,  3,2,1);
        // rowend keeps col_ovf
        step(0,1,0,1,  1,0,0,0,0,1,   0,1,  0,0,0);
        // stride 3 from empty
        step(1,0,0,3,  0,1,0,0,1,1,   1,1,  1,0,0);
        step(1,0,0,3,  1,2,0,0,2,1,   2,1,  2,0,0);
        step(1,0,0,3,  2,3,0,0,3,1,   3,1,  3,0,1);
        step(1,0,0,3,  3,4,0,0,4,1,   4,1,  3,1,0);
        step(1,0,0,3,  4,5,0,1,5,1,   5,1,  3,2,0);
        step(1,0,0,3,  0,5,1,0,6,1,   6,1,  3,0,1);
        step(1,0,0,3,  1,5,2,0,7,1,   7,1,  3,1,0);
        step(1,0,0,3,  2,5,3,1,8,1,   0,1,  3,2,0);
        step(1,0,0,3,  3,5,4,0,9,1,   1,1,  3,0,1);
        step(1,0,0,3,  4,5,0,0,10,1,  2,1,  3,1,0);
        step(1,0,0,3,  0,5,1,1,11,1,  3,1,  3,2,0);
        step(0,1,0,3,  1,0,0,0,0,2,   0,1,  0,0,0);
        // refill to full at row 2, then rowend with enable drops the sample
        step(1,0,0,3,  0,1,0,0,1,2,   1,1,  1,0,0);
        step(1,0,0,3,  1,2,0,0,2,2,   2,1,  2,0,0);
        step(1,0,0,3,  2,3,0,0,3,2,   3,1,  3,0,1);
        step(1,0,0,3,  3,4,0,0,4,2,   4,1,  3,1,0);
        step(1,0,0,3,  4,5,0,1,5,2,   5,1,  3,2,0);
        step(1,1,0,3,  0,0,0,0,0,3,   0,1,  0,0,0);
        // frame_start beats rowend: row and col_ovf clear
        step(0,1,1,3,  0,0,0,0,0,0,   0,0,  0,0,0);
        // stride 0 behaves as 1
        step(1,0,0,0,  0,1,0,0,1,0,   1,0,  1,0,0);
        step(1,0,0,0,  1,2,0,0,2,0,   2,0,  2,0,0);
        step(1,0,0,0,  2,3,0,0,3,0,   3,0,  3,0,1);
        step(1,0,0,0,  3,4,0,0,4,0,   4,0,  3,1,1);
        step(1,0,0,0,  4,5,0,1,5,0,   5,0,  3,2,1);
        step(1,0,0,0,  0,5,1,1,6,0,   6,0,  3,0,1);
        // idle cycle: no pulse, state held
        step(0,0,0,0,  1,5,1,0,6,0,   6,0,  3,0,0);
        // mid-row stride change: shrink below current phase forces a pulse
        step(1,0,0,3,  1,5,2,0,7,0,   7,0,  3,1,0);
        step(1,0,0,3,  2,5,3,0,8,0,   0,1,  3,2,0);
        step(1,0,0,2,  3,5,4,1,9,0,   1,1,  3,0,1);
        step(0,0,1,2,  4,0,0,0,0,0,   0,0,  0,0,0);
        // partial fill, then async reset between edges
        step(1,0,0,1,  0,1,0,0,1,0,   1,0,  1,0,0);
        step(1,0,0,1,  1,2,0,0,2,0,   2,0,  2,0,0);
        step(1,0,0,1,  2,3,0,0,3,0,   3,0,  3,0,1);
        drain();

        @(posedge clk);
        #3;
        chk("pre_async_cnt", int'(a_cnt), 3);
        rst_n = 1'b0;
        #1;
        zero_checks("async");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(1,0,0,1,  0,1,0,0,1,0,   1,0,  1,0,0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dot_window_tracker.md
# dot_window_tracker

Parametrised sliding-window slot tracker for the image pipeline's line-buffer stage. It counts accepted samples in a row until a WIN-deep window is full, then runs a ring pointer over the WIN slots so the oldest entry is overwritten. It emits a strided window-valid pulse, column/row positions and a sticky column-overflow flag. It sits between the pixel fetch logic and the window arithmetic, which uses `first_dot`/`wr_slot` to address its slot registers.

## Interface
- `WIN`, 5: window depth in samples, legal 2..16.
- `CW`, $clog2(WIN+1): width of `cnt`.
- `PW`, $clog2(WIN): width of the slot pointers; minimum 1.
- `SW`, 4: width of `stride`.
- `COL_W`, 8: width of the column counter.
- `ROW_W`, 8: width of the row counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  one sample accepted this cycle.
- `rowend`  in  1  end of current row; synchronous clear of row-local state.
- `frame_start`  in  1  synchronous clear of all state.
- `stride`  in  SW  window-valid spacing in accepted samples; 0 is treated as 1.
- `cnt`  out  CW  fill count, 0..WIN, saturating.
- `first_dot`  out  PW  index of the oldest slot (ring head), 0..WIN-1.
- `wr_slot`  out  PW  combinational; slot the current `enable` writes.
- `win_valid`  out  1  registered one-cycle pulse; a full window is available.
- `col`  out  COL_W  accepted samples in the current row, modulo 2^COL_W.
- `row`  out  ROW_W  completed rows since frame start, modulo 2^ROW_W.
- `col_ovf`  out  1  sticky; `col` wrapped in this frame.

## Operation
- Priority per edge: `frame_start` > `rowend` > `enable`. Lower-priority events in the same cycle are ignored, and the sample is dropped.
- `frame_start`:
  - `cnt`, `first_dot`, stride phase `sph`, `col`, `row`, `col_ovf` ← 0.
  - `win_valid` ← 0.
- `rowend`:
  - `cnt`, `first_dot`, `sph`, `col` ← 0.
  - `row` ← `row`+1, wrapping.
  - `win_valid` ← 0.
  - `col_ovf` is held.
- `enable`, fill phase (`cnt` < WIN):
  - `cnt` ← `cnt`+1; `first_dot` is unchanged.
  - If the new `cnt` == WIN: `win_valid` ← 1 and `sph` ← 0.
- `enable`, full phase (`cnt` == WIN):
  - `cnt` is held.
  - `first_dot` ← (`first_dot` == WIN-1) ? 0 : `first_dot`+1.
  - `sph` ← (`sph`+1 ≥ eff_stride) ? 0 : `sph`+1, where eff_stride = max(`stride`,1).
  - `win_valid` ← 1 iff the new `sph` == 0.
- Any `enable` also sets `col` ← `col`+1. If `col` was 2^COL_W-1, it wraps to 0 and sets `col_ovf`.
- No event: `win_valid` ← 0; all other state is held.
- `wr_slot` = (`cnt` == WIN) ? `first_dot` : `cnt[PW-1:0]`. It is meaningful only while `enable` is high.
- `stride` is sampled live each edge. A change mid-row takes effect on the next full-phase enable. If `sph` ≥ the new eff_stride, the next enable forces `sph` to 0 and pulses.
- Arithmetic: all counters are unsigned. Wrap compares use WIN-1 exactly, never a power-of-2 mask, so non-power-of-2 WIN must be correct.

## Timing
- All outputs except `wr_slot` are registered and update on the `clk` edge that samples the event. Latency is 1 cycle from the event to the output.
- `win_valid` is high for exactly one cycle per qualifying enable. It is never asserted on an edge with no enable.
- Async reset: on `rst_n` low, all registered outputs go to 0 immediately and stay there while low.
  - Reset mid-row discards all state.
  - The first edge after release behaves as if from the empty state.
- Back-to-back enables every cycle are supported with no bubbles.

## Test plan
- Reset, then 5 enables with WIN=5 and `stride`=1:
  - `wr_slot` reads 0,1,2,3,4 and `cnt` goes 1..5.
  - `win_valid` is high only after the 5th edge.
  - `first_dot` stays 0 and `col` reaches 5.
- Continue with 6 more enables:
  - `wr_slot` reads 0,1,2,3,4,0.
  - `first_dot` goes 1,2,3,4,0,1.
  - `win_valid` is high after every edge and `cnt` holds at 5.
- `stride`=3, 11 enables from empty: `win_valid` pulses after enables 5, 8 and 11 only.
- `rowend` and `enable` together while full, with `row`=2:
  - `cnt`, `first_dot` and `col` become 0; `row` becomes 3.
  - `win_valid` is 0 and the sample is dropped.
  - `frame_start` plus `rowend` together clears `row` to 0.
- COL_W=3, 9 enables in one row: `col` wraps 7→0 on the 8th enable and ends at 1. `col_ovf` is set and survives `rowend`, then clears on `frame_start`.
- Pull `rst_n` low asynchronously between edges with `cnt`=3:
  - All outputs are 0 before the next edge.
  - After release, one enable gives `wr_slot`=0 and `cnt`=1.
  - Repeat with WIN=3 to check that `first_dot` wraps 2→0.
